morse_scroll_display: RTL and testbench

Parametrised N-digit 7-segment text display for the Morse decoder, between the decoder's ASCII output and the board HEX pins. Accepts characters over a valid/ready handshake and keeps them in a character buffer. Runs in one of two modes: wrap (circular overwrite) or scroll (shift-in from the right). Supports backspace, a multi-cycle clear command, a saturating fill counter and a blinking cursor in wrap mode.

---
 rtl/morse_scroll_display_pkg.sv | 34 +++
 rtl/morse_scroll_display_if.sv | 21 ++
 rtl/ascii_to_seg7.sv | 61 ++++++
 rtl/morse_scroll_display.sv | 142 ++++++++++++++
 tb/tb_morse_scroll_display.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/morse_scroll_display_pkg.sv
// rtl/morse_scroll_display_pkg.sv - segment constants, control codes and command classifier
package morse_disp_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_UNKNOWN = 7'b0111111;
  localparam logic [6:0] SEG_CURSOR  = 7'b1110111;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    IDLE,
    CLEAR
  } disp_state_t;

  typedef enum logic [1:0] {
    CMD_PRINT,
    CMD_BS,
    CMD_CLEAR
  } disp_cmd_t;

  // Anything that is not backspace or form feed is stored as a character.
  function automatic disp_cmd_t classify(input logic [7:0] code);
    disp_cmd_t cmd;
    case (code)
      ASCII_BS: cmd = CMD_BS;
      ASCII_FF: cmd = CMD_CLEAR;
      default:  cmd = CMD_PRINT;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/morse_scroll_display_if.sv
// rtl/morse_scroll_display_if.sv - character handshake between decoder and display
interface morse_scroll_display_if;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       char_ready;
  logic       mode;

  modport master (
    output ascii_char,
    output char_valid,
    output mode,
    input  char_ready
  );

  modport slave (
    input  ascii_char,
    input  char_valid,
    input  mode,
    output char_ready
  );
endinterface

// File: rtl/ascii_to_seg7.sv
// rtl/ascii_to_seg7.sv - combinational ASCII to active-low 7-segment glyph lookup
module ascii_to_seg7
  import morse_disp_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] seg
);

  logic [7:0] upper;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is 0.
  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) upper = ascii - 8'h20;
    case (upper)
      8'h30: seg = 7'h40;
      8'h31: seg = 7'h79;
      8'h32: seg = 7'h24;
      8'h33: seg = 7'h30;
      8'h34: seg = 7'h19;
      8'h35: seg = 7'h12;
      8'h36: seg = 7'h02;
      8'h37: seg = 7'h78;
      8'h38: seg = 7'h00;
      8'h39: seg = 7'h10;
      8'h41: seg = 7'h08;
      8'h42: seg = 7'h03;
      8'h43: seg = 7'h46;
      8'h44: seg = 7'h21;
      8'h45: seg = 7'h06;
      8'h46: seg = 7'h0E;
      8'h47: seg = 7'h42;
      8'h48: seg = 7'h09;
      8'h49: seg = 7'h4F;
      8'h4A: seg = 7'h61;
      8'h4B: seg = 7'h0A;
      8'h4C: seg = 7'h47;
      8'h4D: seg = 7'h48;
      8'h4E: seg = 7'h2B;
      8'h4F: seg = 7'h40;
      8'h50: seg = 7'h0C;
      8'h51: seg = 7'h18;
      8'h52: seg = 7'h2F;
      8'h53: seg = 7'h12;
      8'h54: seg = 7'h07;
      8'h55: seg = 7'h41;
      8'h56: seg = 7'h63;
      8'h57: seg = 7'h55;
      8'h58: seg = 7'h36;
      8'h59: seg = 7'h11;
      8'h5A: seg = 7'h24;
      8'h20: seg = SEG_BLANK;
      8'h3F: seg = 7'h2C;
      8'h21: seg = 7'h7D;
      8'h2D: seg = 7'h3F;
      8'h2E: seg = 7'h7B;
      default: seg = SEG_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_scroll_display.sv
// rtl/morse_scroll_display.sv - N-digit wrap/scroll text display with clear FSM and blinking cursor
module morse_scroll_display
  import morse_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                              clk,
  input  logic                              reset,
  morse_scroll_display_if.slave             char_if,
  output logic [7*NUM_DIGITS-1:0]           hex,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   fill
);

  localparam int PTR_W  = $clog2(NUM_DIGITS);
  localparam int FILL_W = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_DIGITS - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_DIV - 1);

  disp_state_t state, state_nxt;
  disp_cmd_t   cmd;

  logic [7:0]        char_buf [NUM_DIGITS];
  logic [6:0]        glyph    [NUM_DIGITS];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [PTR_W-1:0]  clr_idx;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  blink_cnt;
  logic              cursor_on;
  logic              show_cursor;
  logic              accept;
  logic              clr_done;
  logic [7*NUM_DIGITS-1:0] hex_q;

  assign char_if.char_ready = (state == IDLE);
  assign accept   = char_if.char_valid && char_if.char_ready;
  assign cmd      = classify(char_if.ascii_char);
  assign clr_done = (clr_idx == LAST_PTR);
  assign ptr_inc  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
  assign ptr_dec  = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cmd == CMD_CLEAR) state_nxt = CLEAR;
      CLEAR:   if (clr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear walks the buffer one entry per cycle; no characters are accepted meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) char_buf[i] <= ASCII_SPACE;
      wr_ptr  <= '0;
      fill_q  <= '0;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      char_buf[clr_idx] <= ASCII_SPACE;
      if (clr_done) begin
        wr_ptr  <= '0;
        fill_q  <= '0;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + PTR_W'(1);
      end
    end else if (accept) begin
      case (cmd)
        CMD_PRINT: begin
          if (char_if.mode) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) char_buf[i] <= char_buf[i-1];
            char_buf[0] <= char_if.ascii_char;
          end else begin
            char_buf[wr_ptr] <= char_if.ascii_char;
            wr_ptr           <= ptr_inc;
          end
          if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
        end
        CMD_BS: begin
          if (char_if.mode) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) char_buf[i] <= char_buf[i+1];
            char_buf[NUM_DIGITS-1] <= ASCII_SPACE;
          end else begin
            char_buf[ptr_dec] <= ASCII_SPACE;
            wr_ptr            <= ptr_dec;
          end
          if (fill_q != '0) fill_q <= fill_q - FILL_W'(1);
        end
        default: clr_idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      cursor_on <= 1'b0;
    end else if (accept) begin
      blink_cnt <= '0;
      cursor_on <= 1'b0;
    end else if (BLINK_DIV != 0) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        cursor_on <= ~cursor_on;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  assign show_cursor = cursor_on && !char_if.mode && (BLINK_DIV != 0);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    ascii_to_seg7 u_glyph (
      .ascii (char_buf[g]),
      .seg   (glyph[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        hex_q[7*i +: 7] <= (show_cursor && wr_ptr == PTR_W'(i)) ? SEG_CURSOR : glyph[i];
    end
  end

  assign hex  = hex_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_morse_scroll_display.sv
// tb/tb_morse_scroll_display.sv - self-checking bench for morse_scroll_display
module tb_morse_scroll_display;

  localparam int N = 6;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7*N-1:0] hex;
  logic [2:0]     fill;

  int n_pass  = 0;
  int n_total = 0;

  morse_scroll_display_if ifc ();

  morse_scroll_display #(.NUM_DIGITS(N), .BLINK_DIV(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .char_if (ifc),
    .hex     (hex),
    .fill    (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Glyph shapes as characters, independent of the RTL lookup structure.
  string      keys = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ ?!-.";
  logic [6:0] shapes [41] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h4F, 7'h61,
    7'h0A, 7'h47, 7'h48, 7'h2B, 7'h40, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07,
    7'h41, 7'h63, 7'h55, 7'h36, 7'h11, 7'h24,
    7'h7F, 7'h2C, 7'h7D, 7'h3F, 7'h7B};

  function automatic logic [6:0] glyph_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    for (int i = 0; i < keys.len(); i++)
      if (keys[i] == u) return shapes[i];
    return 7'h3F;
  endfunction

  // Behavioural model: text buffer, pointer, fill, clear countdown, edges since last accept.
  logic [7:0]     m_buf [N];
  int             m_ptr, m_fill, m_clr_left, m_since;
  logic [7*N-1:0] exp_hex;

  function automatic logic [7*N-1:0] render(input logic m);
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[7*i +: 7] = glyph_of(m_buf[i]);
      if (!m && i == m_ptr && ((m_since / B) % 2 == 1)) r[7*i +: 7] = 7'b1110111;
    end
    return r;
  endfunction

  task automatic model_apply(input logic [7:0] c, input logic m);
    if (c == 8'h0C) begin
      m_clr_left = N;
    end else if (c == 8'h08) begin
      if (m) begin
        for (int i = 0; i < N - 1; i++) m_buf[i] = m_buf[i+1];
        m_buf[N-1] = 8'h20;
      end else begin
        m_ptr = (m_ptr + N - 1) % N;
        m_buf[m_ptr] = 8'h20;
      end
      if (m_fill > 0) m_fill--;
    end else begin
      if (m) begin
        for (int i = N - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = c;
      end else begin
        m_buf[m_ptr] = c;
        m_ptr = (m_ptr + 1) % N;
      end
      if (m_fill < N) m_fill++;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_buf[i] = 8'h20;
      m_ptr = 0; m_fill = 0; m_clr_left = 0; m_since = 0;
      exp_hex = '1;
    end else begin
      exp_hex = render(ifc.mode);
      if (m_clr_left > 0) begin
        m_buf[N - m_clr_left] = 8'h20;
        m_clr_left--;
        if (m_clr_left == 0) begin
          m_ptr = 0;
          m_fill = 0;
        end
        m_since++;
      end else if (ifc.char_valid) begin
        model_apply(ifc.ascii_char, ifc.mode);
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_hex", 64'(hex), 64'(exp_hex));
      check("cyc_fill", 64'(fill), 64'(m_fill));
      check("cyc_ready", 64'(ifc.char_ready), 64'(m_clr_left == 0));
    end
  end

  task automatic send(input logic [7:0] c, input logic m);
    int guard = 0;
    ifc.ascii_char = c;
    ifc.char_valid = 1'b1;
    ifc.mode       = m;
    while (!ifc.char_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    ifc.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input logic m);
    for (int i = 0; i < s.len(); i++) send(s[i], m);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int low;
    ifc.ascii_char = 8'h00;
    ifc.char_valid = 1'b0;
    ifc.mode       = 1'b0;
    idle(3);
    check("reset_hex", 64'(hex), {22'd0, {N{7'h7F}}});
    check("reset_fill", 64'(fill), 64'd0);
    check("reset_ready", 64'(ifc.char_ready), 64'd1);
    #2 reset = 1'b0;
    @(negedge clk);

    send_str("HELLO!", 1'b0);
    idle(1);
    check("hello_hex", 64'(hex), 64'({7'h7D, 7'h40, 7'h47, 7'h47, 7'h06, 7'h09}));
    check("hello_fill", 64'(fill), 64'd6);
    send("A", 1'b0);
    idle(1);
    check("wrap_a_hex", 64'(hex), 64'({7'h7D, 7'h40, 7'h47, 7'h47, 7'h06, 7'h08}));
    check("wrap_a_fill_sat", 64'(fill), 64'd6);

    send_str("12345678", 1'b1);
    idle(1);
    check("scroll_hex", 64'(hex), 64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    check("scroll_fill", 64'(fill), 64'd6);
    send(8'h08, 1'b1);
    idle(1);
    check("scroll_bs_hex", 64'(hex), 64'({7'h7F, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}));
    check("scroll_bs_fill", 64'(fill), 64'd5);

    ifc.ascii_char = 8'h0C;
    ifc.char_valid = 1'b1;
    ifc.mode       = 1'b0;
    @(negedge clk);
    ifc.ascii_char = "Z";
    low = 0;
    while (!ifc.char_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("clear_ready_low", 64'(low), 64'd6);
    @(negedge clk);
    ifc.char_valid = 1'b0;
    idle(1);
    check("clear_z_hex", 64'(hex), 64'({{5{7'h7F}}, 7'h24}));
    check("clear_z_fill", 64'(fill), 64'd1);

    send(8'h0C, 1'b0);
    idle(N);
    send(8'h08, 1'b0);
    idle(5);
    check("bs_empty_cursor", 64'(hex), 64'({7'h77, {5{7'h7F}}}));
    check("bs_empty_fill", 64'(fill), 64'd0);
    idle(4);
    check("cursor_off_phase", 64'(hex), 64'({N{7'h7F}}));
    send("C", 1'b0);
    idle(1);
    check("cursor_restart_off", 64'(hex), 64'({7'h46, {5{7'h7F}}}));
    idle(4);
    check("cursor_on_digit0", 64'(hex), 64'({7'h46, {4{7'h7F}}, 7'h77}));
    ifc.mode = 1'b1;
    idle(6);
    check("scroll_no_cursor", 64'(hex), 64'({7'h46, {5{7'h7F}}}));
    ifc.mode = 1'b0;
    idle(9);

    send(8'h0C, 1'b0);
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("abort_hex", 64'(hex), 64'({N{7'h7F}}));
    check("abort_fill", 64'(fill), 64'd0);
    check("abort_ready", 64'(ifc.char_ready), 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    send(8'h7E, 1'b0);
    idle(1);
    check("unknown_glyph", 64'(hex), 64'({{5{7'h7F}}, 7'h3F}));
    check("model_pin_h", 64'(glyph_of("h")), 64'h09);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
